// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types and defaults for the ALU arbiter.
package alu_pkg;

    typedef enum logic [1:0] {
        OP_A_AND = 2'd0,
        OP_A_ADD = 2'd1,
        OP_A_SUB = 2'd2,
        OP_A_XOR = 2'd3
    } operation_a;

    typedef enum logic [1:0] {
        OP_B_NOT = 2'd0,
        OP_B_OR  = 2'd1,
        OP_B_RSB = 2'd2,
        OP_B_CAT = 2'd3
    } operation_b;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2,
        CLR  = 2'd3
    } arb_state_e;

    typedef struct packed {
        logic       mode;
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
    } alu_req_t;

    localparam int RESULT_LAT_DEF = 2;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-input round-robin picker; on a tie the side not granted last wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester front end that serialises commands onto a shared ALU.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int RESULT_LAT = RESULT_LAT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic       req0_mode,
    input  logic [1:0] req0_op,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic       req1_mode,
    input  logic [1:0] req1_op,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    output logic       rsp_valid,
    output logic       rsp_id,
    output logic [7:0] rsp_data,
    output logic       rsp_irq,
    output logic       alu_enable,
    output logic       alu_enable_a,
    output logic       alu_enable_b,
    output logic [1:0] alu_op_a,
    output logic [1:0] alu_op_b,
    output logic [7:0] alu_in_a,
    output logic [7:0] alu_in_b,
    output logic       alu_irq_clr,
    input  logic       alu_irq,
    input  logic [7:0] alu_out
);

    localparam logic [3:0] CNT_LAST = 4'(RESULT_LAT - 1);

    arb_state_e r_state;
    arb_state_e w_next;
    logic [3:0] r_cnt;
    logic       r_last;
    logic       r_id;
    logic       r_rsp_irq;
    logic [7:0] r_rsp_data;
    alu_req_t   r_cmd;

    logic [1:0] w_gnt;
    logic       w_hs;
    logic       w_last_busy;
    alu_req_t   w_sel;
    operation_a w_op_a;
    operation_b w_op_b;

    rr_arb2 u_rr (
        .req  ({req1_valid, req0_valid}),
        .last (r_last),
        .gnt  (w_gnt)
    );

    assign req0_ready  = (r_state == IDLE) && !rst && w_gnt[0];
    assign req1_ready  = (r_state == IDLE) && !rst && w_gnt[1];
    assign w_hs        = req0_ready | req1_ready;
    assign w_sel       = w_gnt[1] ? {req1_mode, req1_op, req1_a, req1_b}
                                  : {req0_mode, req0_op, req0_a, req0_b};
    assign w_last_busy = (r_state == BUSY) && (r_cnt == CNT_LAST);
    assign w_op_a      = operation_a'(r_cmd.op);
    assign w_op_b      = operation_b'(r_cmd.op);

    assign rsp_id      = r_id;
    assign rsp_data    = r_rsp_data;
    assign rsp_irq     = r_rsp_irq;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        rsp_valid    = 1'b0;
        alu_irq_clr  = 1'b0;
        alu_enable   = 1'b0;
        alu_enable_a = 1'b0;
        alu_enable_b = 1'b0;
        alu_op_a     = 2'd0;
        alu_op_b     = 2'd0;
        alu_in_a     = 8'd0;
        alu_in_b     = 8'd0;
        case (r_state)
            IDLE: begin
                if (w_hs) w_next = BUSY;
            end
            BUSY: begin
                alu_enable   = 1'b1;
                alu_enable_a = ~r_cmd.mode;
                alu_enable_b = r_cmd.mode;
                alu_op_a     = r_cmd.mode ? 2'd0 : w_op_a;
                alu_op_b     = r_cmd.mode ? w_op_b : 2'd0;
                alu_in_a     = r_cmd.a;
                alu_in_b     = r_cmd.b;
                if (w_last_busy) w_next = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                w_next    = r_rsp_irq ? CLR : IDLE;
            end
            CLR: begin
                alu_irq_clr = 1'b1;
                w_next      = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // The command is latched at the handshake so requesters may change inputs freely afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= 4'd0;
            r_last     <= 1'b1;
            r_id       <= 1'b0;
            r_cmd      <= '0;
            r_rsp_data <= 8'd0;
            r_rsp_irq  <= 1'b0;
        end else begin
            if (w_hs) begin
                r_cmd  <= w_sel;
                r_id   <= w_gnt[1];
                r_last <= w_gnt[1];
                r_cnt  <= 4'd0;
            end else if (r_state == BUSY) begin
                r_cnt <= r_cnt + 4'd1;
            end
            if (w_last_busy) begin
                r_rsp_data <= alu_out;
                r_rsp_irq  <= alu_irq;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed scoreboard bench for alu_arbiter with an ALU stub.
module tb_alu_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req0_ready, req0_mode;
    logic [1:0] req0_op;
    logic [7:0] req0_a, req0_b;
    logic       req1_valid, req1_ready, req1_mode;
    logic [1:0] req1_op;
    logic [7:0] req1_a, req1_b;
    logic       rsp_valid, rsp_id, rsp_irq;
    logic [7:0] rsp_data;
    logic       alu_enable, alu_enable_a, alu_enable_b;
    logic [1:0] alu_op_a, alu_op_b;
    logic [7:0] alu_in_a, alu_in_b;
    logic       alu_irq_clr, alu_irq;
    logic [7:0] alu_out;
    logic       irq_en;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       id;
        logic [7:0] data;
        logic       irq;
    } exp_t;
    exp_t sbq[$];
    exp_t mon_e;
    logic prev_irq_rsp = 1'b0;

    always #5 clk = ~clk;

    alu_arbiter #(.RESULT_LAT(2)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_mode(req0_mode),
        .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_mode(req1_mode),
        .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_irq(rsp_irq),
        .alu_enable(alu_enable), .alu_enable_a(alu_enable_a), .alu_enable_b(alu_enable_b),
        .alu_op_a(alu_op_a), .alu_op_b(alu_op_b), .alu_in_a(alu_in_a), .alu_in_b(alu_in_b),
        .alu_irq_clr(alu_irq_clr), .alu_irq(alu_irq), .alu_out(alu_out)
    );

    function automatic logic [7:0] fa(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            2'd0:    return a & b;
            2'd1:    return a + b;
            2'd2:    return a - b;
            default: return a ^ b;
        endcase
    endfunction

    function automatic logic [7:0] fb(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            2'd0:    return ~a;
            2'd1:    return a | b;
            2'd2:    return b - a;
            default: return {a[3:0], b[3:0]};
        endcase
    endfunction

    function automatic logic [7:0] model(input logic mode, input logic [1:0] op,
                                         input logic [7:0] a, input logic [7:0] b);
        return mode ? fb(op, a, b) : fa(op, a, b);
    endfunction

    assign alu_out = !alu_enable ? 8'h00 :
                     (alu_enable_b ? fb(alu_op_b, alu_in_a, alu_in_b)
                                   : fa(alu_op_a, alu_in_a, alu_in_b));
    assign alu_irq = irq_en & alu_enable;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int n, input logic mode, input logic [1:0] op,
                           input logic [7:0] a, input logic [7:0] b);
        if (n == 0) begin
            req0_mode = mode; req0_op = op; req0_a = a; req0_b = b;
        end else begin
            req1_mode = mode; req1_op = op; req1_a = a; req1_b = b;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 of the first BUSY cycle.
    task automatic issue(input int n, input logic mode, input logic [1:0] op,
                         input logic [7:0] a, input logic [7:0] b, input logic irq,
                         input logic push, output int waited);
        logic got;
        got = 1'b0;
        waited = 0;
        set_req(n, mode, op, a, b);
        irq_en = irq;
        if (n == 0) req0_valid = 1'b1; else req1_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            #1;
            if ((n == 0) ? req0_ready : req1_ready) begin
                got = 1'b1;
                break;
            end
            waited++;
            tick();
        end
        check($sformatf("handshake_req%0d", n), {31'b0, got}, 1);
        if (got && push) sbq.push_back('{id: n[0], data: model(mode, op, a, b), irq: irq});
        tick();
        if (n == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_irq_rsp = 1'b0;
        end else begin
            check("ready_mutex", {31'b0, req0_ready & req1_ready}, 0);
            check("irq_clr_timing", {31'b0, alu_irq_clr}, {31'b0, prev_irq_rsp});
            if (rsp_valid) begin
                check("rsp_expected", {31'b0, sbq.size() != 0}, 1);
                if (sbq.size() != 0) begin
                    mon_e = sbq.pop_front();
                    check("rsp_id", {31'b0, rsp_id}, {31'b0, mon_e.id});
                    check("rsp_data", {24'b0, rsp_data}, {24'b0, mon_e.data});
                    check("rsp_irq", {31'b0, rsp_irq}, {31'b0, mon_e.irq});
                end
            end
            prev_irq_rsp = rsp_valid & rsp_irq;
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout observed=hung expected=finish");
        $fatal(1, "timeout");
    end

    initial begin
        int w;
        int found;
        rst = 1'b1;
        irq_en = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        set_req(0, 1'b0, 2'd0, 8'd0, 8'd0);
        set_req(1, 1'b0, 2'd0, 8'd0, 8'd0);

        // Reset: readys held low even with requests pending.
        repeat (2) tick();
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        check("rst_ready0", {31'b0, req0_ready}, 0);
        check("rst_ready1", {31'b0, req1_ready}, 0);
        check("rst_alu_enable", {31'b0, alu_enable}, 0);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 0);
        check("rst_rsp_data", {24'b0, rsp_data}, 0);
        check("rst_irq_clr", {31'b0, alu_irq_clr}, 0);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst = 1'b0;

        // Mode A single command, with operand isolation during BUSY.
        issue(0, 1'b0, 2'b01, 8'h12, 8'h34, 1'b0, 1'b1, w);
        #1;
        check("a_enable_c1", {31'b0, alu_enable}, 1);
        check("a_enable_a", {31'b0, alu_enable_a}, 1);
        check("a_enable_b", {31'b0, alu_enable_b}, 0);
        check("a_op_a", {30'b0, alu_op_a}, 1);
        check("a_op_b", {30'b0, alu_op_b}, 0);
        check("a_in_a", {24'b0, alu_in_a}, 32'h12);
        check("a_in_b", {24'b0, alu_in_b}, 32'h34);
        check("a_no_rsp_c1", {31'b0, rsp_valid}, 0);
        req0_a = 8'hFF;
        tick(); #1;
        check("a_enable_c2", {31'b0, alu_enable}, 1);
        check("iso_in_a", {24'b0, alu_in_a}, 32'h12);
        check("a_no_rsp_c2", {31'b0, rsp_valid}, 0);
        tick(); #1;
        check("a_rsp_valid_c3", {31'b0, rsp_valid}, 1);
        check("a_rsp_data_c3", {24'b0, rsp_data}, 32'h46);
        check("a_idle_enable_c3", {31'b0, alu_enable}, 0);
        check("a_idle_in_a_c3", {24'b0, alu_in_a}, 0);
        tick();

        // Mode B on requester 1, issued in the earliest allowed cycle.
        issue(1, 1'b1, 2'b10, 8'h05, 8'h30, 1'b0, 1'b1, w);
        check("b_no_wait", w, 0);
        #1;
        check("b_rsp_data_hold", {24'b0, rsp_data}, 32'h46);
        check("b_rsp_valid_low", {31'b0, rsp_valid}, 0);
        for (int c = 0; c < 2; c++) begin
            check("b_enable_a", {31'b0, alu_enable_a}, 0);
            check("b_enable_b", {31'b0, alu_enable_b}, 1);
            check("b_op_a", {30'b0, alu_op_a}, 0);
            check("b_op_b", {30'b0, alu_op_b}, 2);
            tick(); #1;
        end
        check("b_rsp_valid", {31'b0, rsp_valid}, 1);
        check("b_rsp_id", {31'b0, rsp_id}, 1);
        tick();

        // Interrupt path: RESP, then CLR, then ready again.
        issue(0, 1'b0, 2'b11, 8'hA5, 8'h0F, 1'b1, 1'b1, w);
        check("irq_no_wait", w, 0);
        set_req(0, 1'b0, 2'b00, 8'h00, 8'h00);
        req0_valid = 1'b1;
        #1;
        check("irq_busy_ready", {31'b0, req0_ready}, 0);
        tick(); tick(); #1;
        check("irq_rsp_valid", {31'b0, rsp_valid}, 1);
        check("irq_rsp_irq", {31'b0, rsp_irq}, 1);
        check("irq_clr_in_resp", {31'b0, alu_irq_clr}, 0);
        check("irq_ready_in_resp", {31'b0, req0_ready}, 0);
        tick(); #1;
        check("irq_clr_pulse", {31'b0, alu_irq_clr}, 1);
        check("irq_ready_in_clr", {31'b0, req0_ready}, 0);
        check("irq_rsp_valid_off", {31'b0, rsp_valid}, 0);
        tick(); #1;
        check("irq_clr_off", {31'b0, alu_irq_clr}, 0);
        check("irq_ready_after", {31'b0, req0_ready}, 1);
        req0_valid = 1'b0;
        irq_en = 1'b0;
        tick();

        // Fairness: both requesters valid from reset.
        rst = 1'b1;
        set_req(0, 1'b0, 2'b01, 8'h10, 8'h01);
        set_req(1, 1'b1, 2'b11, 8'hC3, 8'h5A);
        req0_valid = 1'b1; req1_valid = 1'b1;
        tick(); tick();
        rst = 1'b0;
        for (int g = 0; g < 4; g++) begin
            found = 0;
            for (int i = 0; i < 40; i++) begin
                #1;
                if (req0_ready | req1_ready) begin
                    found = 1;
                    break;
                end
                tick();
            end
            check("fair_grant_seen", found, 1);
            if (found != 0) begin
                check($sformatf("fair_order_%0d", g), {31'b0, req1_ready}, g % 2);
                if (req1_ready) sbq.push_back('{id: 1'b1, data: model(req1_mode, req1_op, req1_a, req1_b), irq: 1'b0});
                else            sbq.push_back('{id: 1'b0, data: model(req0_mode, req0_op, req0_a, req0_b), irq: 1'b0});
            end
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (6) tick();

        // Reset in the first BUSY cycle discards the command.
        issue(0, 1'b0, 2'b01, 8'h20, 8'h22, 1'b0, 1'b0, w);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("mid_rst_enable", {31'b0, alu_enable}, 0);
        check("mid_rst_in_a", {24'b0, alu_in_a}, 0);
        check("mid_rst_rsp_valid", {31'b0, rsp_valid}, 0);
        check("mid_rst_rsp_data", {24'b0, rsp_data}, 0);
        check("mid_rst_rsp_id", {31'b0, rsp_id}, 0);
        check("mid_rst_rsp_irq", {31'b0, rsp_irq}, 0);
        check("mid_rst_irq_clr", {31'b0, alu_irq_clr}, 0);
        repeat (5) tick();
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        check("post_rst_tie_ready0", {31'b0, req0_ready}, 1);
        check("post_rst_tie_ready1", {31'b0, req1_ready}, 0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (3) tick();

        check("scoreboard_drained", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: `clk` is the single clock, and `rst` is the synchronous, active-high reset.
REQ-002 Parameter `RESULT_LAT`, default 2, range 1..15: number of cycles `alu_enable` is held per operation before `alu_out` is sampled.
REQ-003 The ports SHALL be:
- `clk`  in  1  clock.
- `rst`  in  1  synchronous active-high reset.
- `reqN_valid`  in  1  requester N (N=0,1) holds a command.
- `reqN_ready`  out  1  arbiter accepts requester N's command this cycle.
- `reqN_mode`  in  1  0 = mode A, 1 = mode B.
- `reqN_op`  in  2  operation code, interpreted as `operation_a` or `operation_b` according to mode.
- `reqN_a`, `reqN_b`  in  8  operands.
- `rsp_valid`  out  1  one-cycle result strobe.
- `rsp_id`  out  1  index of the requester that owns the result.
- `rsp_data`  out  8  sampled `alu_out`.
- `rsp_irq`  out  1  sampled `alu_irq`.
- `alu_enable`, `alu_enable_a`, `alu_enable_b`  out  1  ALU controls.
- `alu_op_a`, `alu_op_b`  out  2  ALU opcodes.
- `alu_in_a`, `alu_in_b`  out  8  ALU operands.
- `alu_irq_clr`  out  1  ALU interrupt clear.
- `alu_irq`  in  1  ALU interrupt.
- `alu_out`  in  8  ALU result.

Function
REQ-004 The FSM SHALL have exactly four states, IDLE, BUSY, RESP and CLR, and SHALL reset to IDLE.
REQ-005 The ready signals SHALL follow these rules:
- `reqN_ready` is asserted only in IDLE.
- At most one `reqN_ready` is high per cycle.
- `reqN_ready` is combinational from `reqN_valid`.
REQ-006 Arbitration SHALL be two-way round-robin:
- With a single valid requester, that requester is granted.
- With both valid, the requester not granted last is granted.
- The `last_grant` register resets to 1, so requester 0 wins the first tie.
REQ-007 On handshake (`valid` && `ready`), the arbiter SHALL:
- capture mode, op, a, b and the requester id into internal registers;
- go to BUSY with counter = 0.
Later changes on `req*` inputs have no effect on the captured command.
REQ-008 In BUSY, the ALU outputs SHALL be driven as follows:
- `alu_enable` = 1.
- `alu_enable_a` = ~mode and `alu_enable_b` = mode.
- `alu_op_a` = op when mode = 0, else 0; `alu_op_b` = op when mode = 1, else 0.
- `alu_in_a` / `alu_in_b` = the captured operands.
- All of these are stable for the whole of BUSY.
REQ-009 BUSY SHALL last exactly `RESULT_LAT` cycles, counted by a 4-bit counter; on its last cycle the arbiter registers `rsp_data` <= `alu_out` and `rsp_irq` <= `alu_irq`.
REQ-010 In RESP, the arbiter SHALL:
- assert `rsp_valid` = 1 for exactly one cycle, with `rsp_id` = the captured id;
- apply no backpressure;
- go next to CLR if `rsp_irq` = 1, else to IDLE.
REQ-011 In CLR, `alu_irq_clr` SHALL be 1 for exactly one cycle, after which the FSM goes to IDLE; `alu_irq_clr` is 0 in every other state.
REQ-012 Outside BUSY, `alu_enable`, `alu_enable_a`, `alu_enable_b`, `alu_op_*` and `alu_in_*` SHALL all be 0.
REQ-013 Latency with handshake in cycle k:
- BUSY occupies cycles k+1 .. k+`RESULT_LAT`.
- `rsp_valid` is asserted in cycle k+`RESULT_LAT`+1.
- The next handshake is possible in cycle k+`RESULT_LAT`+2 without irq, or k+`RESULT_LAT`+3 with irq.
REQ-014 `rsp_data` and `rsp_irq` SHALL hold their last values until the next sample; `rsp_id` SHALL hold until the next handshake.

Reset
REQ-015 When `rst` = 1 at a clock edge, in any state, the arbiter SHALL:
- set state = IDLE, counter = 0 and `last_grant` = 1;
- set all outputs to 0, including `rsp_data`, `rsp_irq`, `rsp_id` and `alu_irq_clr`;
- discard any in-flight command, with no `rsp_valid` issued for it.
REQ-016 While `rst` = 1, both `reqN_ready` SHALL be 0.

Structure
REQ-017 `alu_pkg` SHALL hold:
- the `arb_state_e` enum (IDLE, BUSY, RESP, CLR);
- the `alu_req_t` packed struct (mode, op[1:0], a[7:0], b[7:0]);
- the `RESULT_LAT_DEF` = 2 constant.
It SHALL reuse the existing `operation_a` / `operation_b` types.
REQ-018 The two-input round-robin picker SHALL be sub-module `rr_arb2`, with inputs req[1:0], last and outputs gnt[1:0].

Verification
REQ-019 Single command, mode A, `RESULT_LAT` = 2:
- Stimulus: `req0` mode 0, op 2'b01, a = 8'h12, b = 8'h34, handshake in cycle 0; stub drives `alu_out` = 8'h46 in cycle 2.
- Required response: `alu_enable` = 1 in cycles 1-2 with `alu_enable_a` = 1, `alu_enable_b` = 0, `alu_op_a` = 1, `alu_in_a` = 8'h12, `alu_in_b` = 8'h34; `rsp_valid` in cycle 3 with `rsp_id` = 0, `rsp_data` = 8'h46.
REQ-020 Mode B: `req1` mode 1, op 2'b10 -> `alu_enable_b` = 1, `alu_enable_a` = 0, `alu_op_b` = 2, `alu_op_a` = 0 throughout BUSY, `rsp_id` = 1.
REQ-021 Fairness: `req0_valid` and `req1_valid` held at 1 from reset for four commands -> grant order is 0, 1, 0, 1, with never both readys high in one cycle.
REQ-022 Interrupt: `alu_irq` = 1 on the last BUSY cycle -> `rsp_irq` = 1 with `rsp_valid`, `alu_irq_clr` = 1 in exactly the next cycle, and no `reqN_ready` until the cycle after that.
REQ-023 Operand isolation: `req0_a` changed from 8'h12 to 8'hFF during BUSY -> `alu_in_a` stays 8'h12.
REQ-024 Reset mid-operation: `rst` pulsed in the first BUSY cycle -> the following cycle has all outputs 0 and no `rsp_valid` ever for that command; a subsequent tie is granted to requester 0.
